// File: rtl/multi_k_low_pass_filter_pkg.sv
// Shared definitions for the multi-channel k-shift low-pass filter:
// k clamp limits, channel-index width helper and the default state type.
package multi_k_low_pass_filter_pkg;

    localparam int K_MIN        = 1;
    localparam int K_MAX        = 40;
    localparam int W_DEFAULT    = 16;
    localparam int FRAC_DEFAULT = 32;
    localparam int SW_DEFAULT   = W_DEFAULT + FRAC_DEFAULT;

    typedef logic signed [SW_DEFAULT-1:0] state_t;

    // A single channel still needs a one-bit index port.
    function automatic int chWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [5:0] clampK(input logic [5:0] k);
        if (k < 6'(K_MIN)) return 6'(K_MIN);
        if (k > 6'(K_MAX)) return 6'(K_MAX);
        return k;
    endfunction

endpackage

// File: rtl/multi_k_low_pass_filter_datapath.sv
// Combinational update of one channel: new x1/y1 state and the output candidate.
module klpf_datapath
    import multi_k_low_pass_filter_pkg::*;
#(
    parameter  int W    = W_DEFAULT,
    parameter  int FRAC = FRAC_DEFAULT,
    localparam int SW   = W + FRAC
) (
    input  logic signed [W-1:0]  i_x,
    input  logic        [5:0]    i_k,
    input  logic signed [SW-1:0] i_x1,
    input  logic signed [SW-1:0] i_y1,
    output logic signed [SW-1:0] o_w1,
    output logic signed [SW-1:0] o_yn,
    output logic signed [W-1:0]  o_cand
);

    logic        [5:0]    w_k;
    logic signed [SW-1:0] w_w4;
    logic signed [SW-1:0] w_leak;

    assign w_k    = clampK(i_k);
    assign o_w1   = {i_x, {FRAC{1'b0}}};
    assign w_w4   = (o_w1 + i_x1) >>> w_k;
    // With k clamped to at least 1 the leak shift is never negative.
    assign w_leak = i_y1 >>> (w_k - 6'd1);
    assign o_yn   = w_w4 + i_y1 - w_leak;
    assign o_cand = o_yn[SW-1:FRAC];

endmodule

// File: rtl/multi_k_low_pass_filter.sv
// Time-multiplexed k-shift low-pass filter, 2-stage pipeline, per-channel state.
// Output hysteresis is compiled in when MULTI_KLPF_HYST_EN is defined.
module multi_k_low_pass_filter
    import multi_k_low_pass_filter_pkg::*;
#(
    parameter  int NCH  = 5,
    parameter  int W    = W_DEFAULT,
    parameter  int FRAC = FRAC_DEFAULT,
    parameter  int HIST = 20,
    localparam int CHW  = chWidth(NCH),
    localparam int SW   = W + FRAC
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [CHW-1:0]      in_ch,
    input  logic signed [W-1:0] x,
    input  logic [5:0]          k,
    output logic                out_valid,
    output logic [CHW-1:0]      out_ch,
    output logic signed [W-1:0] y
);

    if (NCH < 1 || NCH > 16 || HIST < 0) begin : g_paramCheck
        $error("multi_k_low_pass_filter: NCH must be 1..16 and HIST non-negative");
    end

    logic                r_s1Valid;
    logic [CHW-1:0]      r_s1Ch;
    logic signed [W-1:0] r_s1X;
    logic [5:0]          r_s1K;

    logic signed [SW-1:0] r_x1 [NCH];
    logic signed [SW-1:0] r_y1 [NCH];
    logic signed [W-1:0]  r_h  [NCH];

    logic                r_outValid;
    logic [CHW-1:0]      r_outCh;
    logic signed [W-1:0] r_y;

    logic                 w_chOk;
    logic signed [SW-1:0] w_w1;
    logic signed [SW-1:0] w_yn;
    logic signed [W-1:0]  w_cand;
    logic signed [W-1:0]  w_hNew;

    assign w_chOk = (int'(in_ch) < NCH);

    // Out-of-range channels are dropped here so they never reach the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1Valid <= 1'b0;
            r_s1Ch    <= '0;
            r_s1X     <= '0;
            r_s1K     <= '0;
        end else begin
            r_s1Valid <= in_valid && w_chOk;
            r_s1Ch    <= in_ch;
            r_s1X     <= x;
            r_s1K     <= k;
        end
    end

    klpf_datapath #(
        .W    (W),
        .FRAC (FRAC)
    ) u_datapath (
        .i_x    (r_s1X),
        .i_k    (r_s1K),
        .i_x1   (r_x1[r_s1Ch]),
        .i_y1   (r_y1[r_s1Ch]),
        .o_w1   (w_w1),
        .o_yn   (w_yn),
        .o_cand (w_cand)
    );

`ifdef MULTI_KLPF_HYST_EN
    logic signed [W-1:0] w_hCur;
    logic signed [W:0]   w_diff;
    logic        [W:0]   w_absDiff;

    assign w_hCur    = r_h[r_s1Ch];
    assign w_diff    = {w_cand[W-1], w_cand} - {w_hCur[W-1], w_hCur};
    assign w_absDiff = w_diff[W] ? -w_diff : w_diff;
    assign w_hNew    = (w_absDiff >= (W+1)'(HIST)) ? w_cand : w_hCur;
`else
    assign w_hNew = w_cand;
`endif

    // State is read and written in the same cycle, so back-to-back samples on
    // one channel always see the previous result without extra forwarding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NCH; c++) begin
                r_x1[c] <= '0;
                r_y1[c] <= '0;
                r_h[c]  <= '0;
            end
            r_outValid <= 1'b0;
            r_outCh    <= '0;
            r_y        <= '0;
        end else begin
            r_outValid <= r_s1Valid;
            if (r_s1Valid) begin
                r_x1[r_s1Ch] <= w_w1;
                r_y1[r_s1Ch] <= w_yn;
                r_h[r_s1Ch]  <= w_hNew;
                r_outCh      <= r_s1Ch;
                r_y          <= w_hNew;
            end
        end
    end

    assign out_valid = r_outValid;
    assign out_ch    = r_outCh;
    assign y         = r_y;

endmodule

// File: tb/tb_multi_k_low_pass_filter.sv
// Self-checking bench for multi_k_low_pass_filter: directed scenarios plus
// randomized traffic against an arithmetic reference model.
module tb_multi_k_low_pass_filter;

    localparam int NCH  = 5;
    localparam int W    = 16;
    localparam int FRAC = 32;
    localparam int HIST = 20;
    localparam int SW   = W + FRAC;
    localparam int CHW  = multi_k_low_pass_filter_pkg::chWidth(NCH);

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic [CHW-1:0]      in_ch;
    logic signed [W-1:0] x;
    logic [5:0]          k;
    logic                out_valid;
    logic [CHW-1:0]      out_ch;
    logic signed [W-1:0] y;

    int passCount;
    int checkCount;

    typedef struct {
        bit v;
        int ch;
        int y;
    } exp_t;

    longint mX1 [NCH];
    longint mY1 [NCH];
    int     mH  [NCH];
    exp_t   d1, d2, stepExp;
    int     lastCh, lastY;

    multi_k_low_pass_filter #(
        .NCH  (NCH),
        .W    (W),
        .FRAC (FRAC),
        .HIST (HIST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ch     (in_ch),
        .x         (x),
        .k         (k),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .y         (y)
    );

    always #5 clk = ~clk;

    function automatic longint wrapSw(input longint v);
        return (v <<< (64 - SW)) >>> (64 - SW);
    endfunction

    function automatic void clearModel();
        for (int c = 0; c < NCH; c++) begin
            mX1[c] = 0;
            mY1[c] = 0;
            mH[c]  = 0;
        end
        d1 = '{v: 0, ch: 0, y: 0};
        d2 = '{v: 0, ch: 0, y: 0};
        lastCh = 0;
        lastY  = 0;
    endfunction

    // Serial evaluation of one accepted sample in plain 64-bit arithmetic.
    function automatic int modelSample(input int ch, input int xv, input int kv);
        int     kk;
        int     cand;
        int     d;
        longint w1, w4, yn;
        kk   = (kv < 1) ? 1 : ((kv > 40) ? 40 : kv);
        w1   = longint'(xv) <<< FRAC;
        w4   = wrapSw(w1 + mX1[ch]) >>> kk;
        yn   = wrapSw(w4 + mY1[ch] - (mY1[ch] >>> (kk - 1)));
        cand = int'(yn >>> FRAC);
        mX1[ch] = w1;
        mY1[ch] = yn;
`ifdef MULTI_KLPF_HYST_EN
        d = cand - mH[ch];
        if (d < 0) d = -d;
        if (d >= HIST) mH[ch] = cand;
`else
        d = 0;
        mH[ch] = cand + d;
`endif
        return mH[ch];
    endfunction

    // Samples outputs, then drives one input cycle at the falling edge.
    // stepExp holds what the model expects for the observed outputs.
    task automatic step(input bit v, input int ch, input int xv, input int kv,
                        output logic oV, output int oCh, output int oY);
        exp_t cur;
        @(negedge clk);
        oV  = out_valid;
        oCh = int'(out_ch);
        oY  = int'(y);
        stepExp = d2;
        if (d2.v) begin
            lastCh = d2.ch;
            lastY  = d2.y;
        end else begin
            stepExp.ch = lastCh;
            stepExp.y  = lastY;
        end
        cur = '{v: 0, ch: 0, y: 0};
        if (v && ch < NCH) begin
            cur.v  = 1;
            cur.ch = ch;
            cur.y  = modelSample(ch, xv, kv);
        end
        d2 = d1;
        d1 = cur;
        in_valid = v;
        in_ch    = ch[CHW-1:0];
        x        = xv[W-1:0];
        k        = kv[5:0];
    endtask

    task automatic test_reset();
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkCount++;
        if (out_valid !== 1'b0 || out_ch !== '0 || y !== '0)
            $display("[TB] FAIL reset_async: got v=%0b ch=%0d y=%0d, want 0/0/0", out_valid, out_ch, y);
        else passCount++;
        clearModel();
        repeat (2) @(negedge clk);
        checkCount++;
        if (out_valid !== 1'b0 || out_ch !== '0 || y !== '0)
            $display("[TB] FAIL reset_held: got v=%0b ch=%0d y=%0d, want 0/0/0", out_valid, out_ch, y);
        else passCount++;
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic test_ch0_k1();
        bit   expV [4] = '{0, 0, 1, 1};
        int   expY [4] = '{0, 0, 50, 100};
        logic oV;
        int   oCh, oY;
        for (int i = 0; i < 4; i++) begin
            step(i < 2, 0, 100, 1, oV, oCh, oY);
            checkCount++;
            if (oV !== expV[i] || oCh != 0 || oY != expY[i])
                $display("[TB] FAIL ch0_k1 step %0d: got v=%0b ch=%0d y=%0d, want v=%0b ch=0 y=%0d",
                         i, oV, oCh, oY, expV[i], expY[i]);
            else passCount++;
        end
    endtask

    task automatic test_ch1_k2();
        bit   expV  [5] = '{0, 0, 1, 1, 1};
        int   expCh [5] = '{0, 0, 1, 1, 1};
        int   expY  [5] = '{0, 0, 25, 62, 81};
        logic oV;
        int   oCh, oY;
        for (int i = 0; i < 5; i++) begin
            step(i < 3, 1, 100, 2, oV, oCh, oY);
            checkCount++;
            if (oV !== expV[i] || oCh != expCh[i] || oY != expY[i])
                $display("[TB] FAIL ch1_k2 step %0d: got v=%0b ch=%0d y=%0d, want v=%0b ch=%0d y=%0d",
                         i, oV, oCh, oY, expV[i], expCh[i], expY[i]);
            else passCount++;
        end
    endtask

    task automatic test_back_to_back();
        bit   expV  [8] = '{0, 0, 1, 1, 1, 1, 1, 1};
        int   expCh [8] = '{0, 0, 0, 2, 0, 2, 0, 2};
        int   expY  [8] = '{0, 0, 25, -25, 62, -63, 81, -82};
        logic oV;
        int   oCh, oY;
        for (int i = 0; i < 8; i++) begin
            step(i < 6, (i % 2) ? 2 : 0, (i % 2) ? -100 : 100, 2, oV, oCh, oY);
            checkCount++;
            if (oV !== expV[i] || oCh != expCh[i] || oY != expY[i])
                $display("[TB] FAIL interleave step %0d: got v=%0b ch=%0d y=%0d, want v=%0b ch=%0d y=%0d",
                         i, oV, oCh, oY, expV[i], expCh[i], expY[i]);
            else passCount++;
        end
    endtask

    task automatic test_invalid_ch();
        bit   stV   [6] = '{1, 1, 1, 1, 0, 0};
        int   stCh  [6] = '{0, NCH, 7, 0, 0, 0};
        int   stX   [6] = '{100, 1000, -500, 100, 0, 0};
        int   stK   [6] = '{1, 1, 3, 1, 0, 0};
        bit   expV  [6] = '{0, 0, 1, 0, 0, 1};
        int   expY  [6] = '{0, 0, 50, 50, 50, 100};
        logic oV;
        int   oCh, oY;
        for (int i = 0; i < 6; i++) begin
            step(stV[i], stCh[i], stX[i], stK[i], oV, oCh, oY);
            checkCount++;
            if (oV !== expV[i] || oCh != 0 || oY != expY[i])
                $display("[TB] FAIL invalid_ch step %0d: got v=%0b ch=%0d y=%0d, want v=%0b ch=0 y=%0d",
                         i, oV, oCh, oY, expV[i], expY[i]);
            else passCount++;
        end
    endtask

    task automatic test_reset_mid_burst();
        bit   expV [3] = '{0, 0, 1};
        int   expY [3] = '{0, 0, 50};
        logic oV;
        int   oCh, oY;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 100, 1, oV, oCh, oY);
            checkCount++;
            if (oV !== expV[i] || oCh != 0 || oY != expY[i])
                $display("[TB] FAIL burst step %0d: got v=%0b ch=%0d y=%0d, want v=%0b ch=0 y=%0d",
                         i, oV, oCh, oY, expV[i], expY[i]);
            else passCount++;
        end
        #2 reset = 1'b0;
        in_valid = 1'b0;
        #1;
        checkCount++;
        if (out_valid !== 1'b0 || out_ch !== '0 || y !== '0)
            $display("[TB] FAIL burst_reset: got v=%0b ch=%0d y=%0d, want 0/0/0", out_valid, out_ch, y);
        else passCount++;
        clearModel();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        // The first sample right after release must be accepted from zeroed state.
        for (int i = 0; i < 3; i++) begin
            step(i == 0, 0, 100, 1, oV, oCh, oY);
            checkCount++;
            if (oV !== expV[i] || oCh != 0 || oY != expY[i])
                $display("[TB] FAIL after_reset step %0d: got v=%0b ch=%0d y=%0d, want v=%0b ch=0 y=%0d",
                         i, oV, oCh, oY, expV[i], expY[i]);
            else passCount++;
        end
    endtask

    task automatic test_random();
        logic oV;
        int   oCh, oY;
        bit   v;
        int   ch, xv, kv;
        for (int i = 0; i < 402; i++) begin
            v  = (i < 400) && ($urandom_range(0, 3) != 0);
            ch = $urandom_range(0, 7);
            xv = $urandom_range(0, 65535) - 32768;
            kv = $urandom_range(0, 63);
            step(v, ch, xv, kv, oV, oCh, oY);
            checkCount++;
            if (oV !== stepExp.v || oCh != stepExp.ch || oY != stepExp.y)
                $display("[TB] FAIL random step %0d: got v=%0b ch=%0d y=%0d, want v=%0b ch=%0d y=%0d",
                         i, oV, oCh, oY, stepExp.v, stepExp.ch, stepExp.y);
            else passCount++;
        end
    endtask

`ifdef MULTI_KLPF_HYST_EN
    // The second 130 sample settles 10 LSB above the held 120, inside HIST.
    task automatic test_hysteresis();
        int   stX  [8] = '{100, 100, 110, 110, 130, 130, 0, 0};
        bit   expV [8] = '{0, 0, 1, 1, 1, 1, 1, 1};
        int   expY [8] = '{0, 0, 50, 100, 100, 100, 120, 120};
        logic oV;
        int   oCh, oY;
        for (int i = 0; i < 8; i++) begin
            step(i < 6, 0, stX[i], 1, oV, oCh, oY);
            checkCount++;
            if (oV !== expV[i] || oCh != 0 || oY != expY[i])
                $display("[TB] FAIL hyst step %0d: got v=%0b ch=%0d y=%0d, want v=%0b ch=0 y=%0d",
                         i, oV, oCh, oY, expV[i], expY[i]);
            else passCount++;
        end
    endtask
`endif

    initial begin
        passCount  = 0;
        checkCount = 0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_ch      = '0;
        x          = '0;
        k          = '0;
        clearModel();
        stepExp = '{v: 0, ch: 0, y: 0};

        test_reset();
        test_ch0_k1();
        test_reset();
        test_ch1_k2();
        test_reset();
        test_back_to_back();
        test_reset();
        test_invalid_ch();
        test_reset();
        test_reset_mid_burst();
        test_reset();
        test_random();
`ifdef MULTI_KLPF_HYST_EN
        test_reset();
        test_hysteresis();
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
